if_stage: RTL and testbench

Instruction-fetch stage of the ARM pipeline, directly upstream of the decode stage. Holds the program counter and fetches one 32-bit instruction per cycle through a req/ready instruction-memory handshake. Presents a registered {instruction, PC+4, valid} to decode. Honours a hazard freeze through a one-entry skid buffer and redirects on a branch from execute, discarding wrong-path words.

---
 rtl/if_stage_pkg.sv | 14 +
 rtl/if_stage_fetch_skid_buffer.sv | 32 +++
 rtl/if_stage.sv | 141 ++++++++++++++
 tb/tb_if_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants and FSM encoding for the fetch stage
package if_stage_pkg;

  localparam int          INSTRUCTION_LEN  = 32;
  localparam logic [31:0] PC_INCREMENT     = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_stage_fetch_skid_buffer.sv
// rtl/if_stage_fetch_skid_buffer.sv - one-entry {pc, instr} holding slot used while decode is frozen
module if_stage_fetch_skid_buffer
  import if_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       unload,
  input  logic                       flush,
  input  logic [31:0]                load_pc,
  input  logic [INSTRUCTION_LEN-1:0] load_instr,
  output logic [31:0]                pc,
  output logic [INSTRUCTION_LEN-1:0] instr,
  output logic                       full
);

  // Capture one fetched word; flush (branch) and unload both empty the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      instr <= '0;
      full  <= 1'b0;
    end else if (flush || unload) begin
      full <= 1'b0;
    end else if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
      full  <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with freeze skid and branch redirect
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [31:0]                branch_address,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ready,
  input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
  output logic [31:0]                PC,
  output logic [INSTRUCTION_LEN-1:0] Instruction,
  output logic                       valid
);

  fetch_state_e state, state_next;
  logic [31:0] pc_reg, pc_next, pc_plus4;
  logic [31:0] drop_addr, drop_addr_next;
  logic        accepts;
  logic        out_load_fetch, out_load_skid, out_clear;
  logic        skid_load, skid_unload, skid_flush;
  logic [31:0] skid_pc;
  logic [INSTRUCTION_LEN-1:0] skid_instr;
  logic        skid_full;

  assign accepts  = !valid || !freeze;
  assign pc_plus4 = pc_reg + PC_INCREMENT;

  // A DROP cycle keeps presenting the abandoned address until memory completes it.
  assign imem_req  = !rst && (state != FULL);
  assign imem_addr = (state == DROP) ? drop_addr : pc_reg;

  if_stage_fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .unload     (skid_unload),
    .flush      (skid_flush),
    .load_pc    (pc_plus4),
    .load_instr (imem_rdata),
    .pc         (skid_pc),
    .instr      (skid_instr),
    .full       (skid_full)
  );

  // State, program counter and wrong-path address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc_reg    <= RESET_PC;
      drop_addr <= '0;
    end else begin
      state     <= state_next;
      pc_reg    <= pc_next;
      drop_addr <= drop_addr_next;
    end
  end

  // Next-state logic; a branch overrides freeze and whatever the FSM was doing.
  always_comb begin
    state_next     = state;
    pc_next        = pc_reg;
    drop_addr_next = drop_addr;
    out_load_fetch = 1'b0;
    out_load_skid  = 1'b0;
    out_clear      = 1'b0;
    skid_load      = 1'b0;
    skid_unload    = 1'b0;
    skid_flush     = 1'b0;
    if (branch_taken) begin
      pc_next    = branch_address;
      out_clear  = 1'b1;
      skid_flush = 1'b1;
      case (state)
        FETCH: begin
          if (imem_ready) begin
            state_next = FETCH;
          end else begin
            drop_addr_next = pc_reg;
            state_next     = DROP;
          end
        end
        DROP:    state_next = imem_ready ? FETCH : DROP;
        default: state_next = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc_next = pc_plus4;
            if (accepts) begin
              out_load_fetch = 1'b1;
            end else begin
              skid_load  = 1'b1;
              state_next = FULL;
            end
          end else if (accepts) begin
            out_clear = 1'b1;
          end
        end
        FULL: begin
          if (!freeze) begin
            out_load_skid = 1'b1;
            skid_unload   = 1'b1;
            state_next    = FETCH;
          end
        end
        DROP: begin
          out_clear = 1'b1;
          if (imem_ready) state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  // Output register presented to decode; holds bit-stable unless it accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC          <= '0;
      Instruction <= '0;
      valid       <= 1'b0;
    end else if (out_clear) begin
      valid <= 1'b0;
    end else if (out_load_fetch) begin
      PC          <= pc_plus4;
      Instruction <= imem_rdata;
      valid       <= 1'b1;
    end else if (out_load_skid) begin
      PC          <= skid_pc;
      Instruction <= skid_instr;
      valid       <= skid_full;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        valid;

  int passed = 0;
  int total  = 0;

  // Memory model returns the address itself as the instruction word.
  assign imem_rdata = imem_addr;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .PC             (PC),
    .Instruction    (Instruction),
    .valid          (valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
    tick();
    tick();
    total++; if (valid !== 1'b0) $display("FAIL reset_valid got %0h want 0", valid); else passed++;
    total++; if (PC !== 32'h0) $display("FAIL reset_pc got %0h want 0", PC); else passed++;
    total++; if (Instruction !== 32'h0) $display("FAIL reset_instr got %0h want 0", Instruction); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %0h want 0", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got %0h want 0", imem_addr); else passed++;
    rst = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) $display("FAIL release_req got %0h want 1", imem_req); else passed++;
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (valid !== 1'b1) $display("FAIL zw_valid[%0d] got %0h want 1", i, valid); else passed++;
      total++; if (Instruction !== 32'(4*i)) $display("FAIL zw_instr[%0d] got %0h want %0h", i, Instruction, 4*i); else passed++;
      total++; if (PC !== 32'(4*i+4)) $display("FAIL zw_pc[%0d] got %0h want %0h", i, PC, 4*i+4); else passed++;
      total++; if (imem_addr !== 32'(4*i+4)) $display("FAIL zw_addr[%0d] got %0h want %0h", i, imem_addr, 4*i+4); else passed++;
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req !== 1'b1) $display("FAIL ws_req[%0d] got %0h want 1", i, imem_req); else passed++;
      total++; if (imem_addr !== 32'h4) $display("FAIL ws_addr[%0d] got %0h want 4", i, imem_addr); else passed++;
      if (i == 2) imem_ready = 1'b1;
      tick();
      if (i < 2) begin
        total++; if (valid !== 1'b0) $display("FAIL ws_gap_valid[%0d] got %0h want 0", i, valid); else passed++;
      end
    end
    total++; if (valid !== 1'b1) $display("FAIL ws_valid got %0h want 1", valid); else passed++;
    total++; if (Instruction !== 32'h4) $display("FAIL ws_instr got %0h want 4", Instruction); else passed++;
    total++; if (PC !== 32'h8) $display("FAIL ws_pc got %0h want 8", PC); else passed++;
  endtask

  task automatic test_freeze();
    do_reset();
    tick(); tick(); tick();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (valid !== 1'b1 || Instruction !== 32'h8 || PC !== 32'hC)
        $display("FAIL fz_hold[%0d] got %0h/%0h/%0h want 1/8/c", i, valid, Instruction, PC); else passed++;
      total++; if (imem_req !== 1'b0) $display("FAIL fz_req[%0d] got %0h want 0", i, imem_req); else passed++;
    end
    freeze = 1'b0;
    tick();
    total++; if (valid !== 1'b1 || Instruction !== 32'hC || PC !== 32'h10)
      $display("FAIL fz_release got %0h/%0h/%0h want 1/c/10", valid, Instruction, PC); else passed++;
    total++; if (imem_addr !== 32'h10 || imem_req !== 1'b1)
      $display("FAIL fz_release_addr got %0h req %0h want 10 req 1", imem_addr, imem_req); else passed++;
    tick();
    total++; if (valid !== 1'b1 || Instruction !== 32'h10 || PC !== 32'h14)
      $display("FAIL fz_nobubble got %0h/%0h/%0h want 1/10/14", valid, Instruction, PC); else passed++;
  endtask

  task automatic test_branch_wait();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    imem_ready = 1'b0;
    branch_taken = 1'b1;
    branch_address = 32'h100;
    tick();
    branch_taken = 1'b0;
    total++; if (valid !== 1'b0) $display("FAIL br_valid0 got %0h want 0", valid); else passed++;
    total++; if (imem_addr !== 32'h14 || imem_req !== 1'b1)
      $display("FAIL br_drop_addr0 got %0h req %0h want 14 req 1", imem_addr, imem_req); else passed++;
    tick();
    total++; if (imem_addr !== 32'h14) $display("FAIL br_drop_addr1 got %0h want 14", imem_addr); else passed++;
    imem_ready = 1'b1;
    tick();
    total++; if (valid !== 1'b0) $display("FAIL br_discard_valid got %0h want 0", valid); else passed++;
    total++; if (imem_addr !== 32'h100) $display("FAIL br_target_addr got %0h want 100", imem_addr); else passed++;
    tick();
    total++; if (valid !== 1'b1 || Instruction !== 32'h100 || PC !== 32'h104)
      $display("FAIL br_deliver got %0h/%0h/%0h want 1/100/104", valid, Instruction, PC); else passed++;
  endtask

  task automatic test_branch_freeze();
    do_reset();
    tick(); tick(); tick();
    freeze = 1'b1;
    tick();
    branch_taken = 1'b1;
    branch_address = 32'h200;
    tick();
    branch_taken = 1'b0;
    total++; if (valid !== 1'b0) $display("FAIL bf_valid got %0h want 0", valid); else passed++;
    total++; if (imem_addr !== 32'h200 || imem_req !== 1'b1)
      $display("FAIL bf_addr got %0h req %0h want 200 req 1", imem_addr, imem_req); else passed++;
    freeze = 1'b0;
    tick();
    total++; if (valid !== 1'b1 || Instruction !== 32'h200 || PC !== 32'h204)
      $display("FAIL bf_deliver got %0h/%0h/%0h want 1/200/204", valid, Instruction, PC); else passed++;
    tick();
    total++; if (valid !== 1'b1 || Instruction !== 32'h204 || PC !== 32'h208)
      $display("FAIL bf_skid_flushed got %0h/%0h/%0h want 1/204/208", valid, Instruction, PC); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    tick();
    imem_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    total++; if (valid !== 1'b0 || PC !== 32'h0 || Instruction !== 32'h0)
      $display("FAIL rm_outputs got %0h/%0h/%0h want 0/0/0", valid, Instruction, PC); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL rm_req got %0h want 0", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL rm_addr got %0h want 0", imem_addr); else passed++;
    rst = 1'b0;
    imem_ready = 1'b1;
    tick();
    total++; if (valid !== 1'b1 || Instruction !== 32'h0 || PC !== 32'h4)
      $display("FAIL rm_restart got %0h/%0h/%0h want 1/0/4", valid, Instruction, PC); else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_freeze();
    test_branch_wait();
    test_branch_freeze();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
